cronometru_display: RTL

- Downstream consumer of the stopwatch `count[20:0]` output.
- Repeatedly converts the binary count to 7 BCD digits using a sequential double-dabble FSM.
- Holds the latest result in a register.
- Drives a time-multiplexed, active-low 7-digit seven-segment display, with a fixed decimal point so the readout shows seconds.hundredths.

---
 rtl/cronometru_display_if.sv | 21 ++
 rtl/cronometru_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cronometru_display_if.sv
// Bus between the stopwatch count source and the BCD/seven-segment display block.
interface cronometru_display_if;
    logic [20:0] count;
    logic        freeze;
    logic [27:0] bcd;
    logic        conv_done;
    logic        busy;
    logic [6:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output count, freeze,
        input  bcd, conv_done, busy, an, seg, dp
    );

    modport slave (
        input  count, freeze,
        output bcd, conv_done, busy, an, seg, dp
    );
endinterface

// File: rtl/cronometru_display.sv
// Sequential double-dabble conversion of the stopwatch count plus a multiplexed 7-digit display.
// Define CRONOMETRU_DISPLAY_BLANK_EN to blank leading-zero digits above the decimal point.
module cronometru_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DP_POS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cronometru_display_if.slave   io_bus
);
    localparam int unsigned CNT_W  = 21;
    localparam int unsigned BCD_W  = 28;
    localparam int unsigned SREG_W = CNT_W + BCD_W;
    localparam int unsigned N_DIG  = 7;
    localparam int unsigned ITER_W = 5;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(CNT_W - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic                w_shift;
    logic                w_finish;
    logic [SREG_W-1:0]   r_sreg;
    logic [SREG_W-1:0]   w_sreg_adj;
    logic [ITER_W-1:0]   r_iter;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_conv_done;
    logic                r_busy;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [2:0]          r_idx;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [6:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!io_bus.freeze) w_state_next = S_SHIFT;
            S_SHIFT: if (r_iter == LAST_ITER) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE:  w_load   = !io_bus.freeze;
            S_SHIFT: w_shift  = 1'b1;
            S_DONE:  w_finish = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        w_sreg_adj = r_sreg;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (r_sreg[CNT_W + 4*i +: 4] >= 4'd5)
                w_sreg_adj[CNT_W + 4*i +: 4] = r_sreg[CNT_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg      <= '0;
            r_iter      <= '0;
            r_bcd       <= '0;
            r_conv_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_conv_done <= w_finish;
            if (w_load) begin
                r_sreg <= {BCD_W'(0), io_bus.count};
                r_iter <= '0;
                r_busy <= 1'b1;
            end
            if (w_shift) begin
                r_sreg <= w_sreg_adj << 1;
                r_iter <= r_iter + ITER_W'(1);
            end
            if (w_finish) begin
                r_bcd  <= r_sreg[SREG_W-1:CNT_W];
                r_busy <= 1'b0;
            end
        end
    end

    // Free-running scan; runs regardless of freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == 3'(N_DIG - 1)) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        w_digit = '0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (r_idx == 3'(i)) w_digit = r_bcd[4*i +: 4];
        end
    end

`ifdef CRONOMETRU_DISPLAY_BLANK_EN
    logic w_zero_above;

    // Walk from the top digit down; a digit blanks only if it and all above are zero.
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = 1'b0;
        for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_bcd[4*i +: 4] == 4'd0);
            if ((r_idx == 3'(i)) && w_zero_above && (i > int'(DP_POS)))
                w_blank = 1'b1;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 7'h7F;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(7'(1) << r_idx);
            r_seg <= w_blank ? 7'h7F : f_decode(w_digit);
            r_dp  <= (r_idx != 3'(DP_POS));
        end
    end

    assign io_bus.bcd       = r_bcd;
    assign io_bus.conv_done = r_conv_done;
    assign io_bus.busy      = r_busy;
    assign io_bus.an        = r_an;
    assign io_bus.seg       = r_seg;
    assign io_bus.dp        = r_dp;
endmodule
